// File: rtl/sfp_norm_unit.sv
// sfp_norm_unit: buffers up to `depth` psum rows, accumulates the sum of
// absolute values of every element, then streams each row out divided by the
// total (q = (|e| << frac) / total, saturated, sign restored).
// Optional macro DUAL_CORE_SUM_EN: the local sum is exchanged with the peer
// core over sum_out/sum_in before dividing, and total = local + peer.
module sfp_norm_unit #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int depth   = 16,
  parameter int sw      = 28,
  parameter int frac    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [col*bw_psum-1:0] in_data,
  output logic                   in_ready,
  input  logic                   norm,
  output logic [sw-1:0]          sum_out,
  output logic                   sum_out_valid,
  input  logic [sw-1:0]          sum_in,
  input  logic                   sum_in_valid,
  output logic                   out_valid,
  output logic [col*bw_psum-1:0] out_data,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int row_w  = col * bw_psum;
  localparam int pw     = $clog2(depth);
  localparam int cw     = pw + 1;
  localparam int rabs_w = bw_psum + $clog2(col);
  localparam int acc_w  = ((sw > rabs_w) ? sw : rabs_w) + 1;
  localparam int nw     = bw_psum + frac;
  localparam int dw     = (nw > sw) ? nw : sw;
  localparam logic [sw-1:0]      sum_max = '1;
  localparam logic [bw_psum-1:0] q_max   = {1'b0, {(bw_psum-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACC, EXCH, DIV} state_t;

  state_t            state, state_next;
  logic [row_w-1:0]  mem [depth];
  logic [pw-1:0]     wr_ptr, rd_ptr;
  logic [cw-1:0]     count, count_acc;
  logic [sw-1:0]     local_sum, local_sum_acc, total;
  logic [rabs_w-1:0] row_abs;
  logic [row_w-1:0]  div_row;
  logic              accept, pop, last_done;

  // Magnitude of a signed element; the most negative value maps to 2^(bw_psum-1).
  function automatic logic [bw_psum-1:0] abs_of(input logic [bw_psum-1:0] e);
    return e[bw_psum-1] ? -e : e;
  endfunction

  // Unsigned add that clamps at the top of the sw-bit range.
  function automatic logic [sw-1:0] sat_add(input logic [sw-1:0] a, input logic [acc_w-1:0] b);
    logic [acc_w-1:0] s;
    s = acc_w'(a) + b;
    return (s > acc_w'(sum_max)) ? sum_max : s[sw-1:0];
  endfunction

  // One normalised element: scaled magnitude over total, clamped, sign restored.
  function automatic logic [bw_psum-1:0] norm_elem(input logic [bw_psum-1:0] e,
                                                   input logic [sw-1:0]      t);
    logic [nw-1:0]      num;
    logic [dw-1:0]      q;
    logic [bw_psum-1:0] qs;
    if (t == '0) return '0;
    num = {abs_of(e), {frac{1'b0}}};
    q   = dw'(num) / dw'(t);
    qs  = (q > dw'(q_max)) ? q_max : q[bw_psum-1:0];
    return e[bw_psum-1] ? -qs : qs;
  endfunction

  assign in_ready  = ((state == IDLE) || (state == ACC)) && (count < cw'(depth));
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign pop       = (state == DIV) && (count != '0) && (!out_valid || out_ready);
  assign last_done = (state == DIV) && (count == '0) && out_valid && out_ready;

  // Absolute-value sum of the incoming row.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    row_abs = '0;
    for (int i = 0; i < col; i++)
      row_abs = row_abs + rabs_w'(abs_of(in_data[i*bw_psum +: bw_psum]));
  end

  assign local_sum_acc = accept ? sat_add(local_sum, acc_w'(row_abs)) : local_sum;
  assign count_acc     = count + cw'(accept);

  // Normalised version of the row at the read pointer.
  always_comb begin
    div_row = '0;
    for (int i = 0; i < col; i++)
      div_row[i*bw_psum +: bw_psum] = norm_elem(mem[rd_ptr][i*bw_psum +: bw_psum], total);
  end

`ifdef DUAL_CORE_SUM_EN
  assign sum_out       = local_sum;
  assign sum_out_valid = (state == EXCH);
`else
  logic unused_peer;
  assign sum_out       = '0;
  assign sum_out_valid = 1'b0;
  assign unused_peer   = ^{sum_in, sum_in_valid};
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACC: begin
        if (norm) begin
`ifdef DUAL_CORE_SUM_EN
          state_next = EXCH;
`else
          state_next = (count_acc != '0) ? DIV : IDLE;
`endif
        end else if (accept) begin
          state_next = ACC;
        end
      end
`ifdef DUAL_CORE_SUM_EN
      EXCH: if (sum_in_valid) state_next = (count != '0) ? DIV : IDLE;
`endif
      DIV:  if (last_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Row buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the row buffer has no reset; count and pointers define what is valid.
    if (accept) mem[wr_ptr] <= in_data;
  end

  // Pointers, counters, sums and the registered output row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      local_sum <= '0;
      total     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) wr_ptr <= wr_ptr + pw'(1);
          count     <= count_acc;
          local_sum <= local_sum_acc;
`ifndef DUAL_CORE_SUM_EN
          if (norm) total <= local_sum_acc;
`endif
        end
`ifdef DUAL_CORE_SUM_EN
        EXCH: begin
          if (sum_in_valid) begin
            if (count != '0) begin
              total <= sat_add(local_sum, acc_w'(sum_in));
            end else begin
              local_sum <= '0;
              total     <= '0;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
            end
          end
        end
`endif
        DIV: begin
          if (pop) begin
            out_data  <= div_row;
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + pw'(1);
            count     <= count - cw'(1);
          end else if (last_done) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            local_sum <= '0;
            total     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_norm_unit.sv
// Directed testbench for sfp_norm_unit (works with or without DUAL_CORE_SUM_EN;
// in the dual build the peer sum is 0 except where a test sets it).
module tb_sfp_norm_unit;

  localparam int COL = 8, BW = 20, DEPTH = 16, SW = 28, FRAC = 8;
  localparam int ROW_W = COL * BW;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [ROW_W-1:0] in_data;
  logic             in_ready;
  logic             norm;
  logic [SW-1:0]    sum_out;
  logic             sum_out_valid;
  logic [SW-1:0]    sum_in;
  logic             sum_in_valid;
  logic             out_valid;
  logic [ROW_W-1:0] out_data;
  logic             out_ready;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  logic [ROW_W-1:0] got_q[$];
  int               stall_bad;
  bit               drain_timeout;

  sfp_norm_unit #(.col(COL), .bw_psum(BW), .depth(DEPTH), .sw(SW), .frac(FRAC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .norm(norm), .sum_out(sum_out), .sum_out_valid(sum_out_valid), .sum_in(sum_in),
    .sum_in_valid(sum_in_valid), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] set_e(input logic [ROW_W-1:0] r, input int i, input int v);
    r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] fill(input int v);
    logic [ROW_W-1:0] r = '0;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  task automatic push(input logic [ROW_W-1:0] row);
    in_data = row; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic do_norm();
    norm = 1'b1;
    step();
    norm = 1'b0;
  endtask

  // Answers the peer-sum request in the dual build; no-op otherwise.
  task automatic exchange(input int peer);
`ifdef DUAL_CORE_SUM_EN
    int c = 0;
    while (sum_out_valid !== 1'b1 && c < 20) begin step(); c++; end
    vectors++;
    if (sum_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL exchange_wait: sum_out_valid=%b, required 1", sum_out_valid);
    end
    sum_in = SW'(peer); sum_in_valid = 1'b1;
    step();
    sum_in_valid = 1'b0; sum_in = '0;
`endif
  endtask

  // Collects n output rows; optionally toggles out_ready and records stall instability.
  task automatic drain(input int n, input bit toggle);
    int cyc = 0;
    bit stalled = 1'b0;
    logic [ROW_W-1:0] held = '0;
    got_q.delete(); stall_bad = 0;
    while (got_q.size() < n && cyc < 200) begin
      if (stalled && (out_valid !== 1'b1 || out_data !== held)) stall_bad++;
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
      stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
      held = out_data;
      step(); cyc++;
    end
    drain_timeout = (got_q.size() < n);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sum_out_valid !== 1'b0 || sum_out !== '0) begin
      miscompares++;
      $display("FAIL reset_init: ov=%b busy=%b ir=%b sov=%b so=%0d, required 0 0 1 0 0",
               out_valid, busy, in_ready, sum_out_valid, sum_out);
    end
    push(fill(3)); push(fill(4));
    do_norm(); exchange(0);
    step();
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_div: ov=%b busy=%b, required 1 1", out_valid, busy);
    end
    reset = 1'b0; step(); reset = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sum_out_valid !== 1'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: ov=%b busy=%b ir=%b sov=%b od=%h, required 0 0 1 0 0",
               out_valid, busy, in_ready, sum_out_valid, out_data);
    end
  endtask

  task automatic test_single();
    logic [ROW_W-1:0] exp_row;
    push(set_e(set_e('0, 0, 256), 1, -256));
    do_norm(); exchange(0);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_pop_cycle: ov=%b busy=%b, required 0 1", out_valid, busy);
    end
    step();
    exp_row = set_e(set_e('0, 0, 128), 1, -128);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== exp_row) begin
      miscompares++;
      $display("FAIL single_out: ov=%b od=%h, required 1 %h", out_valid, out_data, exp_row);
    end
    drain(1, 1'b0);
    vectors++;
    if (drain_timeout || got_q[0] !== exp_row || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: timeout=%b ov=%b busy=%b, required 0 0 0", drain_timeout, out_valid, busy);
    end
  endtask

  task automatic test_min_value();
    logic [ROW_W-1:0] exp_row;
    push(set_e(set_e('0, 0, -524288), 1, -524288));
    do_norm(); exchange(0);
    drain(1, 1'b0);
    exp_row = set_e(set_e('0, 0, -128), 1, -128);
    vectors++;
    if (drain_timeout || got_q[0] !== exp_row) begin
      miscompares++;
      $display("FAIL min_value: timeout=%b row=%h, required %h", drain_timeout, got_q[0], exp_row);
    end
  endtask

  task automatic test_zero_total();
    push('0);
    do_norm(); exchange(0);
    drain(1, 1'b0);
    vectors++;
    if (drain_timeout || got_q[0] !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_total: timeout=%b row=%h busy=%b, required row 0 busy 0", drain_timeout, got_q[0], busy);
    end
  endtask

`ifdef DUAL_CORE_SUM_EN
  task automatic test_exchange();
    push(fill(10));
    do_norm();
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (sum_out_valid !== 1'b1 || sum_out !== SW'(80)) begin
        miscompares++;
        $display("FAIL exch_hold[%0d]: sov=%b so=%0d, required 1 80", c, sum_out_valid, sum_out);
      end
      step();
    end
    sum_in = SW'(80); sum_in_valid = 1'b1; step(); sum_in_valid = 1'b0; sum_in = '0;
    vectors++;
    if (sum_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL exch_drop: sov=%b, required 0", sum_out_valid);
    end
    drain(1, 1'b0);
    vectors++;
    if (drain_timeout || got_q[0] !== fill(16)) begin
      miscompares++;
      $display("FAIL exch_out: timeout=%b row=%h, required %h", drain_timeout, got_q[0], fill(16));
    end
  endtask
`endif

  task automatic test_empty_norm();
    do_norm();
`ifdef DUAL_CORE_SUM_EN
    vectors++;
    if (sum_out_valid !== 1'b1 || sum_out !== '0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_exch: sov=%b so=%0d busy=%b, required 1 0 1", sum_out_valid, sum_out, busy);
    end
    sum_in = SW'(50); sum_in_valid = 1'b1; step(); sum_in_valid = 1'b0; sum_in = '0;
`endif
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || sum_out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL empty_idle[%0d]: busy=%b ov=%b sov=%b ir=%b, required 0 0 0 1",
                 c, busy, out_valid, sum_out_valid, in_ready);
      end
      step();
    end
  endtask

  task automatic test_full_backpressure();
    logic [ROW_W-1:0] exp_row;
    for (int k = 0; k <= DEPTH; k++) begin
      in_data  = (k < DEPTH) ? set_e(set_e('0, 0, k + 1), 1, -(15 - k)) : fill(1000);
      in_valid = 1'b1;
      vectors++;
      if (in_ready !== (k < DEPTH)) begin
        miscompares++;
        $display("FAIL full_in_ready[%0d]: %b, required %b", k, in_ready, (k < DEPTH));
      end
      step();
    end
    in_valid = 1'b0; in_data = '0;
    do_norm(); exchange(0);
    drain(DEPTH, 1'b1);
    vectors++;
    if (drain_timeout || stall_bad !== 0) begin
      miscompares++;
      $display("FAIL full_flow: timeout=%b stall_errors=%0d, required 0 0", drain_timeout, stall_bad);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      exp_row = set_e(set_e('0, 0, k + 1), 1, -(15 - k));
      vectors++;
      if (got_q[k] !== exp_row) begin
        miscompares++;
        $display("FAIL full_row[%0d]: %h, required %h", k, got_q[k], exp_row);
      end
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_extra: ov=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [ROW_W-1:0] exp_rows [3];
    push(set_e('0, 0, 64));
    push(set_e('0, 0, -184));
    in_data = fill(1); in_valid = 1'b1; norm = 1'b1;
    step();
    in_valid = 1'b0; in_data = '0; norm = 1'b0;
`ifdef DUAL_CORE_SUM_EN
    vectors++;
    if (sum_out !== SW'(256)) begin
      miscompares++;
      $display("FAIL b2b_sum: so=%0d, required 256", sum_out);
    end
`endif
    exchange(0);
    norm = 1'b1; step(); norm = 1'b0;
    vectors++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_norm_in_div: busy=%b ov=%b, required 1 1", busy, out_valid);
    end
    drain(3, 1'b0);
    exp_rows[0] = set_e('0, 0, 64);
    exp_rows[1] = set_e('0, 0, -184);
    exp_rows[2] = fill(1);
    vectors++;
    if (drain_timeout || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_flow: timeout=%b busy=%b, required 0 0", drain_timeout, busy);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_rows[k]) begin
        miscompares++;
        $display("FAIL b2b_row[%0d]: %h, required %h", k, got_q[k], exp_rows[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; norm = 1'b0;
    sum_in = '0; sum_in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    test_reset();
    test_single();
    test_min_value();
    test_zero_total();
`ifdef DUAL_CORE_SUM_EN
    test_exchange();
`endif
    test_empty_norm();
    test_full_backpressure();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sfp_norm_unit.md
Name: sfp_norm_unit

Overview:
- Parametrised successor to the single-row softmax-normalisation stage that sits after the core's psum readout.
- Buffers a block of up to `depth` psum rows and accumulates the sum of absolute values of every element.
- Optionally exchanges that partial sum with the peer core over a valid/hold handshake, then streams each buffered row out divided by the global sum.
- Sits between core psum output and the chip output mux, one instance per core.

Parameters:
- col, 8, elements per row
- bw_psum, 20, signed element width
- depth, 16, max rows buffered per normalisation block (power of 2)
- sw, 28, unsigned sum width
- frac, 8, fractional bits of the quotient (`out = (|e| << frac) / total`, sign restored)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  in_data valid
- in_data  in  col*bw_psum  signed psum row, element i at [bw_psum*(i+1)-1 : bw_psum*i]
- in_ready  out  1  row can be accepted
- norm  in  1  single-cycle pulse: close accumulation, start normalisation
- sum_out  out  sw  local abs-sum offered to peer
- sum_out_valid  out  1  sum_out valid
- sum_in  in  sw  peer abs-sum
- sum_in_valid  in  1  sum_in valid
- out_valid  out  1  out_data valid
- out_data  out  col*bw_psum  normalised signed row
- out_ready  in  1  downstream accepts out_data
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; local_sum, total, row count, rd/wr pointers = 0.
  - All outputs 0, except in_ready=1.
  - Applies mid-operation too; buffered rows are discarded.
- States: IDLE, ACC, EXCH, DIV.
- Accept rule: a row is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE || state==ACC) && count<depth.
  - in_valid while in_ready==0 is ignored (row dropped, no sum update).
- On accept:
  - Row is written at wr_ptr; count++.
  - local_sum += Σ|e_i|, with |e| of the most negative value = 2^(bw_psum-1).
  - The addition saturates at 2^sw-1.
  - IDLE→ACC.
- norm in IDLE or ACC → EXCH on the next edge.
  - If in_valid&&in_ready in the same cycle, that row is included in local_sum and the buffer.
  - norm in EXCH or DIV is ignored.
- EXCH:
  - sum_out=local_sum and sum_out_valid=1 are asserted from the first EXCH cycle and held.
  - When sum_in_valid==1: total = local_sum + sum_in, saturating; sum_out_valid drops next cycle.
  - If count>0 → DIV, else → IDLE.
  - sum_in_valid outside EXCH is ignored.
- DIV:
  - Rows are popped in write order.
  - out_data is registered: popped row appears with out_valid=1 one cycle after the pop.
  - out_data and out_valid are held stable while out_ready==0.
  - The next pop occurs on the cycle out_valid&&out_ready, giving 1 row/cycle throughput when out_ready stays high.
- Per element in DIV:
  - q = (|e| << frac) / total (unsigned integer divide, truncate).
  - q is saturated to 2^(bw_psum-1)-1, and the sign of e is restored.
  - If total==0, all outputs are 0.
- After the last row handshakes: → IDLE; local_sum, total, count and pointers clear; out_valid=0.
- Wrap-around: pointers are log2(depth) bits and wrap naturally; count is log2(depth)+1 bits.
- busy=1 in ACC, EXCH and DIV.

Optional Feature:
- Macro: DUAL_CORE_SUM_EN.
- Defined:
  - EXCH handshake as described.
  - total = local_sum + sum_in.
- Undefined:
  - EXCH state is absent; norm goes IDLE/ACC→DIV directly with total=local_sum (or → IDLE if count==0).
  - sum_out and sum_out_valid are tied to 0; sum_in and sum_in_valid are unused.

Test Plan:
1. Reset with pending rows and state DIV, reset=0 for 1 cycle → next cycle out_valid=0, busy=0, in_ready=1, sum_out_valid=0.
2. Single-core (macro undefined): push row e0=256, e1=-256, others 0 → local_sum=512; norm → out e0=128, e1=-128 (frac=8), rest 0, out_valid 1 cycle after pop.
3. Exchange (macro defined): push row all elements 10 (local 80); norm.
   - sum_out=80, sum_out_valid held for 5 cycles until sum_in=80 with sum_in_valid.
   - total=160; out element = (10<<8)/160 = 16.
4. Full/backpressure: push 17 rows with in_valid held → in_ready low after the 16th, 17th not counted.
   - norm, with out_ready toggling 1/0 → 16 outputs in order, data stable during stalls.
5. Empty norm: norm with no rows (macro defined) → EXCH with sum_out=0; after sum_in_valid, → IDLE, no out_valid.
6. Simultaneous norm+in_valid on a row of all 1s after 2 prior rows → 3 rows output; local_sum includes +8.
   - norm asserted during DIV has no effect.
